priority_irq_ctrl: RTL
======================

# priority_irq_ctrl

Parametrised, registered priority interrupt controller: N active-low request lines are synchronised, edge-detected and latched as pending; the highest-priority unmasked pending line is presented as an encoded index over a valid/ready handshake and cleared on acceptance. Successor to the combinational 8-line encoder, with arbitrary width, masking, pending storage, overflow detection and optional round-robin priority. Sits between board-level request inputs and the consuming control FSM.

## Interface
- N, 8, number of request lines (N >= 2)
- IDX_W, $clog2(N), derived localparam, index width; not overridable
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_n  in  N  request lines, active-low, asynchronous to clk
- en_n  in  1  capture enable, active-low; high blocks new captures
- mask  in  N  1 = line ineligible for selection (still captured)
- irq_ready  in  1  consumer accepts current index
- ovf_clr  in  1  clears ovf
- irq_valid  out  1  irq_idx holds a pending line
- irq_idx  out  IDX_W  encoded index of presented line
- any_pending  out  1  OR of all pending bits (masked included)
- ovf  out  1  sticky: request edge on an already-pending line

## Operation
- Input path: 2-flop synchroniser (s1, s2) then prev register; falling edge = !s2 & prev.
- Capture: falling edge on line i with en_n low sets pending[i]. en_n high: edge discarded, existing pending unaffected and still served.
- Eligible = pending & ~mask & ~clear_vec, where clear_vec = one-hot(irq_idx) when irq_valid & irq_ready.
- Fixed priority (default): highest eligible index wins (index N-1 highest).
- Output register loads when !irq_valid or (irq_valid & irq_ready): irq_valid <= |eligible, irq_idx <= winner (unchanged if none).
- Hold rule: while irq_valid & !irq_ready, irq_idx and irq_valid are frozen; later higher-priority arrivals or mask changes never retract or replace the presented index.
- Accept: irq_valid & irq_ready clears pending[irq_idx] at that edge.
- Simultaneous set and clear on same line: set wins; pending stays 1, no ovf.
- Edge on line already pending and not being cleared: pending unchanged, ovf <= 1.
- ovf_clr and new overflow same cycle: ovf stays 1.
- Masking a pending line: stays pending, becomes eligible when unmasked.

## Timing
- Reset values: s1, s2, prev all ones (no spurious edge after reset); pending 0; irq_valid 0; irq_idx 0; ovf 0; any_pending 0; round-robin pointer N-1.
- Reset mid-handshake: all pending discarded, irq_valid low next cycle, regardless of irq_ready.
- Latency: req_n low before edge E0 -> s2 low after E1 -> pending set at E2 -> irq_valid high after E3 (any_pending high after E2).
- Throughput: one accepted index per cycle with irq_ready held high; next winner presented the cycle after accept with no bubble.
- irq_ready may be high with irq_valid low; no effect.

## Configuration
- ROUND_ROBIN_EN defined: pointer register holds last accepted index; search starts at pointer-1 going downward, wrapping N-1 after 0; pointer updates only on accept. Lines presented one after another in rotating order.
- Not defined: fixed priority, no pointer register.

## Structure
- Package priority_irq_pkg: default N, helper function for one-hot of an index.
- Sub-module priority_pick: combinational, N-bit vector in, highest-set index and any-set out; instantiated once (fixed) or twice (round-robin: pointer-masked vector and full vector, masked result preferred).

## Test plan
- Reset release with req_n = 8'hFF -> irq_valid, any_pending, ovf stay 0 for 20 cycles.
- req_n[5] falls at E0 -> irq_valid=1, irq_idx=5 after E3; ready pulse -> irq_valid=0 next cycle, any_pending=0.
- Lines 2, 6, 7 fall same cycle, ready held high -> indices 7, 6, 2 on consecutive cycles; with ROUND_ROBIN_EN and pointer=6 -> 2, 7, 6.
- Present idx 3, hold ready low, line 7 falls -> irq_idx stays 3 until accept, then 7.
- Line 4 pending, second falling edge on 4 -> ovf=1; ovf_clr -> 0; edge on 4 in same cycle as its accept -> pending kept, ovf 0.
- mask=8'h80, line 7 falls -> any_pending=1, irq_valid=0; clear mask -> idx 7 presented next cycle; en_n high during edge on line 1 -> not captured.

Source files
------------

// File: rtl/priority_irq_pkg.sv
// rtl/priority_irq_pkg.sv - shared defaults and one-hot helper for the priority interrupt controller
package priority_irq_pkg;

    localparam int N_DEFAULT = 8;
    localparam int MAX_N     = 256;

    // Callers truncate the result to their own line count.
    function automatic logic [MAX_N-1:0] one_hot(input int unsigned idx);
        logic [MAX_N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/priority_pick.sv
// rtl/priority_pick.sv - combinational highest-set-bit encoder with found flag
module priority_pick #(
    parameter  int N     = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        idx   = '0;
        found = |vec;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/priority_irq_ctrl.sv
// rtl/priority_irq_ctrl.sv - registered priority interrupt controller; ROUND_ROBIN_EN selects rotating priority
module priority_irq_ctrl
    import priority_irq_pkg::*;
#(
    parameter  int N     = N_DEFAULT,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_n,
    input  logic             en_n,
    input  logic [N-1:0]     mask,
    input  logic             irq_ready,
    input  logic             ovf_clr,
    output logic             irq_valid,
    output logic [IDX_W-1:0] irq_idx,
    output logic             any_pending,
    output logic             ovf
);

    logic [N-1:0]     s1, s2, prev;
    logic [N-1:0]     pending;
    logic [N-1:0]     set_vec, clear_vec, eligible;
    logic             accept, ovf_event;
    logic [IDX_W-1:0] win;
    logic             win_found;

    assign set_vec   = en_n ? '0 : (~s2 & prev);
    assign accept    = irq_valid & irq_ready;
    assign clear_vec = accept ? N'(one_hot(32'(irq_idx))) : '0;
    assign eligible  = pending & ~mask & ~clear_vec;
    // A set on the line being accepted this cycle is a fresh request, not an overflow.
    assign ovf_event = |(set_vec & pending & ~clear_vec);
    assign any_pending = |pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= '1;
            s2      <= '1;
            prev    <= '1;
            pending <= '0;
            ovf     <= 1'b0;
        end else begin
            s1      <= req_n;
            s2      <= s1;
            prev    <= s2;
            pending <= (pending & ~clear_vec) | set_vec;
            if (ovf_event)    ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr;
    logic [N-1:0]     below_ptr;
    logic [IDX_W-1:0] idx_lo, idx_all;
    logic             found_lo, found_all;

    always_comb begin
        below_ptr = '0;
        for (int i = 0; i < N; i++) begin
            below_ptr[i] = (IDX_W'(i) < ptr);
        end
    end

    priority_pick #(.N(N)) u_pick_lo (
        .vec   (eligible & below_ptr),
        .idx   (idx_lo),
        .found (found_lo)
    );

    priority_pick #(.N(N)) u_pick_all (
        .vec   (eligible),
        .idx   (idx_all),
        .found (found_all)
    );

    // Prefer lines below the last accepted one; otherwise wrap to the top.
    assign win       = found_lo ? idx_lo : idx_all;
    assign win_found = found_all;

    always_ff @(posedge clk) begin
        if (rst)         ptr <= IDX_W'(N - 1);
        else if (accept) ptr <= irq_idx;
    end
`else
    priority_pick #(.N(N)) u_pick (
        .vec   (eligible),
        .idx   (win),
        .found (win_found)
    );
`endif

    // Presented index is frozen until the consumer accepts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_valid <= 1'b0;
            irq_idx   <= '0;
        end else if (!irq_valid || irq_ready) begin
            irq_valid <= win_found;
            if (win_found) irq_idx <= win;
        end
    end

endmodule
